// File: rtl/rstseq_pkg.sv
// Shared state type, counter-width helper and restart-counter constants for reset_sequencer.
package rstseq_pkg;

  typedef enum logic [1:0] {
    ST_PRE     = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } rstseq_state_e;

  localparam int RESTART_W = 8;
  localparam logic [RESTART_W-1:0] RESTART_MAX = 8'd255;

  // Width of a counter that must hold values 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [RESTART_W-1:0] sat_inc(input logic [RESTART_W-1:0] v);
    return (v == RESTART_MAX) ? v : v + RESTART_W'(1);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser for the manual request followed by a consecutive-high debounce counter.
module sync_debounce
  import rstseq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level_q;
  logic [DB_W-1:0] r_cnt;
  logic            w_level;

  // Combinational on the synchronised sample so the sample completing the run is acted on at that edge.
  assign w_level = r_sync2 && (r_cnt == DB_MAX);
  assign o_level = w_level;
  assign o_rise  = w_level & ~r_level_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_async;
      r_sync2   <= r_sync1;
      r_level_q <= w_level;
      if (!r_sync2) begin
        r_cnt <= '0;
      end else if (r_cnt != DB_MAX) begin
        r_cnt <= r_cnt + DB_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staggered multi-domain reset generator with debounced manual restart and restart counter.
// Optional watchdog restart is enabled by defining RSTSEQ_WATCHDOG_EN.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int NUM_DOMAINS     = 4,
  parameter int HOLD_CYCLES     = 4,
  parameter int STAGGER_CYCLES  = 2,
  parameter int DEBOUNCE_CYCLES = 3
`ifdef RSTSEQ_WATCHDOG_EN
  , parameter int WDT_CYCLES    = 200
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   manual,
`ifdef RSTSEQ_WATCHDOG_EN
  input  logic                   kick,
  output logic                   wdt_fired,
`endif
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   busy,
  output logic                   done,
  output logic [RESTART_W-1:0]   restart_count
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int STAG_W = cnt_width(STAGGER_CYCLES);
  localparam int IDX_W  = cnt_width(NUM_DOMAINS);

  rstseq_state_e          r_state, w_state_nxt;
  logic [HOLD_W-1:0]      r_hold, w_hold_nxt;
  logic [STAG_W-1:0]      r_stag, w_stag_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [NUM_DOMAINS-1:0] r_domain_rst, w_domain_rst_nxt;
  logic [RESTART_W-1:0]   r_count, w_count_nxt;
  logic                   r_busy, r_done;
  logic                   w_deb, w_deb_rise;
`ifdef RSTSEQ_WATCHDOG_EN
  localparam int WDT_W = cnt_width(WDT_CYCLES);
  logic [WDT_W-1:0]       r_wdt, w_wdt_nxt;
  logic                   r_wdt_fired, w_wdt_fired_nxt;
  assign wdt_fired = r_wdt_fired;
`endif

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_debounce (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_async (manual),
    .o_level (w_deb),
    .o_rise  (w_deb_rise)
  );

  assign domain_rst    = r_domain_rst;
  assign busy          = r_busy;
  assign done          = r_done;
  assign restart_count = r_count;

  // Next state: a debounced request overrides everything and pins the sequence at the start of ASSERT.
  always_comb begin
    w_state_nxt      = r_state;
    w_hold_nxt       = r_hold;
    w_stag_nxt       = r_stag;
    w_idx_nxt        = r_idx;
    w_domain_rst_nxt = r_domain_rst;
    w_count_nxt      = w_deb_rise ? sat_inc(r_count) : r_count;
`ifdef RSTSEQ_WATCHDOG_EN
    w_wdt_nxt        = '0;
    w_wdt_fired_nxt  = 1'b0;
`endif
    if (w_deb) begin
      w_state_nxt      = ST_ASSERT;
      w_hold_nxt       = '0;
      w_stag_nxt       = '0;
      w_idx_nxt        = '0;
      w_domain_rst_nxt = '1;
    end else begin
      case (r_state)
        ST_PRE: begin
          w_state_nxt      = ST_ASSERT;
          w_hold_nxt       = '0;
          w_domain_rst_nxt = '1;
        end
        ST_ASSERT: begin
          if (r_hold == HOLD_W'(HOLD_CYCLES - 1)) begin
            w_domain_rst_nxt[0] = 1'b0;
            w_stag_nxt          = '0;
            w_idx_nxt           = IDX_W'(1);
            w_state_nxt         = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end
        end
        ST_RELEASE: begin
          if (r_stag == STAG_W'(STAGGER_CYCLES - 1)) begin
            w_domain_rst_nxt[r_idx] = 1'b0;
            w_stag_nxt              = '0;
            if (r_idx == IDX_W'(NUM_DOMAINS - 1)) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_stag_nxt = r_stag + STAG_W'(1);
          end
        end
        ST_RUN: begin
          w_domain_rst_nxt = '0;
`ifdef RSTSEQ_WATCHDOG_EN
          if (kick) begin
            w_wdt_nxt = '0;
          end else if (r_wdt == WDT_W'(WDT_CYCLES - 1)) begin
            w_state_nxt      = ST_ASSERT;
            w_hold_nxt       = '0;
            w_domain_rst_nxt = '1;
            w_wdt_fired_nxt  = 1'b1;
            w_count_nxt      = sat_inc(r_count);
          end else begin
            w_wdt_nxt = r_wdt + WDT_W'(1);
          end
`endif
        end
        default: begin
          w_state_nxt      = ST_PRE;
          w_domain_rst_nxt = '0;
        end
      endcase
    end
  end

  // State and registered outputs; status is derived from the next state so it lines up with domain_rst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_PRE;
      r_hold       <= '0;
      r_stag       <= '0;
      r_idx        <= '0;
      r_domain_rst <= '0;
      r_count      <= '0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
`ifdef RSTSEQ_WATCHDOG_EN
      r_wdt        <= '0;
      r_wdt_fired  <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_stag       <= w_stag_nxt;
      r_idx        <= w_idx_nxt;
      r_domain_rst <= w_domain_rst_nxt;
      r_count      <= w_count_nxt;
      r_busy       <= (w_state_nxt != ST_RUN);
      r_done       <= (w_state_nxt == ST_RUN);
`ifdef RSTSEQ_WATCHDOG_EN
      r_wdt        <= w_wdt_nxt;
      r_wdt_fired  <= w_wdt_fired_nxt;
`endif
    end
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised successor to the board-level power-on reset generator. Produces NUM_DOMAINS active-high domain resets with a power-on pulse. Domains are released in a staggered order (domain 0 first), so the UART, clock-tick and user-logic domains come out of reset in a defined order. The manual reset request is synchronised and debounced, and busy/done status plus a saturating restart counter are exported to top-level logic.

Parameters:
NUM_DOMAINS, 4, number of reset outputs (1..16)
HOLD_CYCLES, 4, clocks all domains stay asserted after the sequence starts (>=1)
STAGGER_CYCLES, 2, clocks between release of domain i and domain i+1 (>=1)
DEBOUNCE_CYCLES, 3, consecutive synchronised-high samples needed to accept manual (>=1)

Ports:
clk  input  1  sequencing clock (board tick clock, e.g. hz100)
reset_n  input  1  asynchronous, active-low reset
manual  input  1  raw manual reset request (button combination), asynchronous, active-high
domain_rst  output  NUM_DOMAINS  per-domain reset, active-high
busy  output  1  sequence in progress
done  output  1  all domains released
restart_count  output  8  number of accepted manual requests, saturates at 255

Behaviour:
- reset_n low, asynchronously: state PRE, domain_rst=0, busy=1, done=0, restart_count=0, synchroniser and debounce cleared. domain_rst starts low so that every domain sees a clean rising edge.
- States:
  - PRE -> ASSERT on the first clk edge after reset_n deasserts.
  - ASSERT: domain_rst all 1s. Hold counter runs for HOLD_CYCLES clocks.
  - On the HOLD_CYCLES-th edge -> RELEASE, and domain_rst[0] clears on that same edge.
  - RELEASE: every STAGGER_CYCLES edges clear the next domain bit, in ascending index order.
  - The edge that clears bit NUM_DOMAINS-1 enters RUN.
  - RUN: domain_rst=0, busy=0, done=1. Stays in RUN until a manual request.
- busy=1 in PRE/ASSERT/RELEASE; done=1 only in RUN. Both are registered.
- Default timeline (reset_n rises before edge 1):
  - edge1 domain_rst=1111
  - edge5 1110
  - edge7 1100
  - edge9 1000
  - edge11 0000, done=1
- Manual path:
  - 2-flop synchroniser feeds a debounce counter.
  - debounced goes high once DEBOUNCE_CYCLES consecutive synchronised-high samples are seen.
  - It drops on the first synchronised-low sample.
  - Latency from manual rising to domain_rst all 1s is 2+DEBOUNCE_CYCLES edges (5 at defaults).
- Debounced high in any state (PRE, ASSERT, RELEASE, RUN): enter ASSERT, domain_rst all 1s, hold counter held at 0.
- Counting of HOLD_CYCLES starts on the first edge after debounced falls.
- A manual request mid-RELEASE re-asserts all domains, including ones already released.
- restart_count increments once per debounced rising edge and saturates at 255 (no wrap).
- Pulses shorter than DEBOUNCE_CYCLES synchronised samples are ignored and cause no state change.
- Counter widths are $clog2-derived from the parameters. No arithmetic overflow is possible inside the valid parameter ranges.

Optional Feature:
RSTSEQ_WATCHDOG_EN.
- Defined: adds parameter WDT_CYCLES (default 200) and input port kick (1 bit, synchronous to clk).
  - In RUN, a watchdog counter increments each clock and clears on kick=1.
  - When it reaches WDT_CYCLES-1 with no kick, the next edge enters ASSERT: the full sequence is re-run and restart_count increments (saturating).
  - wdt_fired output (1 bit) pulses high for exactly one clock on that edge.
  - The counter is held at 0 outside RUN.
- Undefined: no kick/wdt_fired ports, no watchdog logic.

Decomposition:
- Package rstseq_pkg holds:
  - the state enum typedef (PRE, ASSERT, RELEASE, RUN)
  - the localparam width helpers for the hold, stagger and debounce counters
  - the restart counter width constant (8) and saturation value
- Sub-module sync_debounce contains the 2-flop synchroniser and debounce counter, parametrised by DEBOUNCE_CYCLES. It outputs a debounced level and a one-cycle rise pulse.

Test Plan:
- Power-on: reset_n low 3 clocks, then high, manual=0 -> domain_rst sequence 0000, 1111 (edge1), 1110 (edge5), 1100 (edge7), 1000 (edge9), 0000 (edge11). done=1 from edge11, busy=0.
- Manual in RUN: manual high 10 clocks -> domain_rst=1111 at 5th edge after rise; restart_count=1. After release: 4 hold clocks, then staggered release as above.
- Glitch: manual high for 2 clocks in RUN -> no change, domain_rst=0000, restart_count=0.
- Mid-sequence: accepted manual while domain_rst=1100 -> all 1111 again; sequence restarts from HOLD after release.
- Saturation: 300 accepted manual pulses -> restart_count=255, no wrap.
- Async reset mid-RELEASE: reset_n low between edges -> immediately domain_rst=0000, busy=1, done=0, restart_count=0. With RSTSEQ_WATCHDOG_EN and WDT_CYCLES=200, no kick in RUN -> wdt_fired pulses on the 200th clock and the sequence re-runs.
